// File: rtl/vend_dispense_scheduler_pkg.sv
// Shared definitions for the vending dispense scheduler: default sizing,
// FSM state encodings and a small state-classification helper.
package vend_dispense_scheduler_pkg;

    // Default sizing shared with the vending_machine channels
    localparam int N_CH_DEF        = 4;
    localparam int CH_W_DEF        = 2;
    localparam int PEND_W_DEF      = 2;
    localparam int COOL_CYC_DEF    = 3;
    localparam int TIMEOUT_CYC_DEF = 15;

    typedef logic [2:0] state_t;

    // Scheduler FSM encodings (kept as plain constants for legacy tools)
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_COOL  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    // The motor is considered occupied in every state except IDLE and FAULT
    function automatic logic state_is_busy(input state_t st);
        return (st == ST_START) || (st == ST_WAIT) || (st == ST_COOL);
    endfunction

endpackage

// File: rtl/vend_dispense_scheduler_rr_arbiter.sv
// Combinational rotating-priority arbiter: picks the first requesting index
// scanning upward from ptr+1 (wrapping at N_CH), so the last winner has the
// lowest priority on the next pick.
module vend_dispense_scheduler_rr_arbiter
    import vend_dispense_scheduler_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int CH_W = CH_W_DEF
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic            gnt_vld,
    output logic [CH_W-1:0] gnt_idx
);

    int              sum_s;
    logic [CH_W-1:0] cand_s;
    logic            hit_s;

    // Walk the N_CH candidates in priority order and latch the first hit
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = {CH_W{1'b0}};
        sum_s   = 0;
        cand_s  = {CH_W{1'b0}};
        hit_s   = 1'b0;
        for (int off = 1; off <= N_CH; off++) begin
            sum_s   = int'(ptr) + off;
            cand_s  = (sum_s >= N_CH) ? CH_W'(sum_s - N_CH) : CH_W'(sum_s);
            hit_s   = req[cand_s] & ~gnt_vld;
            gnt_idx = hit_s ? cand_s : gnt_idx;
            gnt_vld = gnt_vld | hit_s;
        end
    end

endmodule

// File: rtl/vend_dispense_scheduler.sv
// Shares one dispense motor between N_CH vending channels. Requests are
// queued in per-channel saturating counters and served round-robin, one
// motor cycle at a time: IDLE -> START -> WAIT -> COOL -> IDLE, with a
// sticky FAULT when the motor never reports completion.
module vend_dispense_scheduler
    import vend_dispense_scheduler_pkg::*;
#(
    parameter int N_CH        = N_CH_DEF,
    parameter int CH_W        = CH_W_DEF,
    parameter int PEND_W      = PEND_W_DEF,
    parameter int COOL_CYC    = COOL_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] vend_req,
    input  logic            motor_done,
    output logic            motor_start,
    output logic [CH_W-1:0] motor_sel,
    output logic            busy,
    output logic [N_CH-1:0] pend_full,
    output logic [N_CH-1:0] drop_pulse,
    output logic            fault
);

    // One timer serves both the WAIT timeout and the COOL hold
    localparam int TMR_MAX = (TIMEOUT_CYC > COOL_CYC) ? TIMEOUT_CYC : COOL_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
    localparam logic [TMR_W-1:0]  TMR_ZERO  = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0]  TMR_ONE   = {{(TMR_W-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0]  TMR_TO    = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0]  TMR_COOL  = TMR_W'(COOL_CYC - 1);

    // Saturating up/down step; simultaneous inc and dec cancel out
    function automatic logic [PEND_W-1:0] pend_step(
        input logic [PEND_W-1:0] cnt,
        input logic              inc,
        input logic              dec
    );
        logic [PEND_W-1:0] res;
        case ({inc, dec})
            2'b10:   res = (cnt == PEND_MAX)  ? cnt : cnt + {{(PEND_W-1){1'b0}}, 1'b1};
            2'b01:   res = (cnt == PEND_ZERO) ? cnt : cnt - {{(PEND_W-1){1'b0}}, 1'b1};
            default: res = cnt;
        endcase
        return res;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [TMR_W-1:0]  timer_r;
    logic [TMR_W-1:0]  timer_nxt_s;
    logic [CH_W-1:0]   ptr_r;
    logic [PEND_W-1:0] pend_r     [N_CH];
    logic [PEND_W-1:0] pend_nxt_s [N_CH];
    logic [N_CH-1:0]   pend_nz_s;
    logic [N_CH-1:0]   dec_s;
    logic [N_CH-1:0]   drop_s;
    logic [N_CH-1:0]   full_s;
    logic              gnt_vld_s;
    logic [CH_W-1:0]   gnt_idx_s;
    logic              grant_s;

    logic              motor_start_r;
    logic [CH_W-1:0]   motor_sel_r;
    logic              busy_r;
    logic [N_CH-1:0]   pend_full_r;
    logic [N_CH-1:0]   drop_pulse_r;
    logic              fault_r;

    vend_dispense_scheduler_rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req     (pend_nz_s),
        .ptr     (ptr_r),
        .gnt_vld (gnt_vld_s),
        .gnt_idx (gnt_idx_s)
    );

    // Next-state and timer logic; motor_done is only honoured in WAIT and
    // beats the timeout when both land on the same edge
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        grant_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (gnt_vld_s) begin
                    grant_s     = 1'b1;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                timer_nxt_s = TMR_ZERO;
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (motor_done) begin
                    timer_nxt_s = TMR_ZERO;
                    state_nxt_s = ST_COOL;
                end else if (timer_r == TMR_TO) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    timer_nxt_s = timer_r + TMR_ONE;
                end
            end
            ST_COOL: begin
                if (timer_r == TMR_COOL) begin
                    timer_nxt_s = TMR_ZERO;
                    state_nxt_s = ST_IDLE;
                end else begin
                    timer_nxt_s = timer_r + TMR_ONE;
                end
            end
            ST_FAULT: begin
                state_nxt_s = ST_FAULT;
            end
            default: begin
                timer_nxt_s = TMR_ZERO;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Per-channel counter update plus the full/drop flags derived from it
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            dec_s[i]      = grant_s && (gnt_idx_s == CH_W'(i));
            pend_nxt_s[i] = pend_step(pend_r[i], vend_req[i], dec_s[i]);
            drop_s[i]     = vend_req[i] & ~dec_s[i] & (pend_r[i] == PEND_MAX);
            full_s[i]     = (pend_nxt_s[i] == PEND_MAX);
            pend_nz_s[i]  = (pend_r[i] != PEND_ZERO);
        end
    end

    // FSM state, timer and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            timer_r <= TMR_ZERO;
            ptr_r   <= CH_W'(N_CH - 1);
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
            if (grant_s) begin
                ptr_r <= gnt_idx_s;
            end
        end
    end

    // Pending counter array
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                pend_r[i] <= PEND_ZERO;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                pend_r[i] <= pend_nxt_s[i];
            end
        end
    end

    // Registered outputs, all computed from next-state values
    always_ff @(posedge clk) begin
        if (rst) begin
            motor_start_r <= 1'b0;
            motor_sel_r   <= {CH_W{1'b0}};
            busy_r        <= 1'b0;
            pend_full_r   <= {N_CH{1'b0}};
            drop_pulse_r  <= {N_CH{1'b0}};
            fault_r       <= 1'b0;
        end else begin
            motor_start_r <= (state_nxt_s == ST_START);
            busy_r        <= state_is_busy(state_nxt_s);
            pend_full_r   <= full_s;
            drop_pulse_r  <= drop_s;
            fault_r       <= fault_r | (state_nxt_s == ST_FAULT);
            if (grant_s) begin
                motor_sel_r <= gnt_idx_s;
            end
        end
    end

    assign motor_start = motor_start_r;
    assign motor_sel   = motor_sel_r;
    assign busy        = busy_r;
    assign pend_full   = pend_full_r;
    assign drop_pulse  = drop_pulse_r;
    assign fault       = fault_r;

endmodule
